// File: rtl/regfile_writeback_pkg.sv
// Shared core types for the writeback stage: default widths and the buffered
// load-result entry.
package regfile_writeback_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Synchronous FIFO of load-result entries with a registered occupancy count.
// The head reads from storage, so a pushed entry is visible one cycle later.
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: ALU results win, buffered load results fill
// idle cycles, and a pending bitvector tracks outstanding load destinations.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  input  logic                  issue_valid_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  output logic                  issue_ready_o,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic                  busy_a_o,
  output logic                  busy_b_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  wb_entry_t             push_entry, head;
  logic                  fifo_empty, fifo_full;
  logic                  lsu_push, lsu_pop, issue_fire;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [NREGS-1:0]      pending_q, pending_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  assign push_entry.rd   = WB_ADDR_W'(lsu_rd_i);
  assign push_entry.data = WB_DATA_W'(lsu_data_i);
  assign head_rd         = ADDR_WIDTH'(head.rd);

  assign lsu_ready_o   = !fifo_full;
  assign lsu_push      = lsu_valid_i && lsu_ready_o;
  assign lsu_pop       = !alu_valid_i && !fifo_empty;
  assign issue_ready_o = !pending_q[issue_rd_i] || (issue_rd_i == '0);
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_rd_i != '0);
  assign busy_a_o      = pending_q[raddr_a_i];
  assign busy_b_o      = pending_q[raddr_b_i];

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (lsu_push),
    .push_data_i (push_entry),
    .pop_i       (lsu_pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_valid_i) begin
      we_d    = (alu_rd_i != '0);
      waddr_d = alu_rd_i;
      wdata_d = alu_data_i;
    end else if (lsu_pop) begin
      we_d    = (head_rd != '0);
      waddr_d = head_rd;
      wdata_d = DATA_WIDTH'(head.data);
    end
  end

  // A new issue to a register being retired in the same cycle must stay pending,
  // so the set is applied after the clear.
  always_comb begin
    pending_d = pending_q;
    if (lsu_pop)    pending_d[head_rd]    = 1'b0;
    if (issue_fire) pending_d[issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign we_a_o    = we_q;
  assign waddr_a_o = waddr_q;
  assign wdata_a_o = wdata_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with hand-computed expected values.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ready_o;
  logic [4:0]  raddr_a_i, raddr_b_i;
  logic        busy_a_o, busy_b_o;
  logic        we_a_o;
  logic [4:0]  waddr_a_o;
  logic [31:0] wdata_a_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid_i   (alu_valid_i),
    .alu_rd_i      (alu_rd_i),
    .alu_data_i    (alu_data_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_ready_o   (lsu_ready_o),
    .lsu_rd_i      (lsu_rd_i),
    .lsu_data_i    (lsu_data_i),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_ready_o (issue_ready_o),
    .raddr_a_i     (raddr_a_i),
    .raddr_b_i     (raddr_b_i),
    .busy_a_o      (busy_a_o),
    .busy_b_o      (busy_b_o),
    .we_a_o        (we_a_o),
    .waddr_a_o     (waddr_a_o),
    .wdata_a_o     (wdata_a_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    chk({tag, ".we"}, 64'(we_a_o), 64'(we));
    if (we) begin
      chk({tag, ".waddr"}, 64'(waddr_a_o), 64'(wa));
      chk({tag, ".wdata"}, 64'(wdata_a_o), 64'(wd));
    end
  endtask

  initial begin
    rst = 1'b1;
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
    lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_data_i = '0;
    issue_valid_i = 1'b0; issue_rd_i = '0;
    raddr_a_i = '0; raddr_b_i = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst.we",    64'(we_a_o), 64'd0);
    chk("rst.waddr", 64'(waddr_a_o), 64'd0);
    chk("rst.wdata", 64'(wdata_a_o), 64'd0);
    chk("rst.lsu_ready", 64'(lsu_ready_o), 64'd1);
    issue_rd_i = 5'd7; #1;
    chk("rst.issue_ready", 64'(issue_ready_o), 64'd1);
    raddr_a_i = 5'd7; #1;
    chk("rst.busy_a", 64'(busy_a_o), 64'd0);

    // Single ALU write, visible exactly one cycle
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
    step();
    alu_valid_i = 1'b0;
    chk_wr("alu1", 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    chk_wr("alu1.after", 1'b0, 5'd0, 32'd0);

    // Issue rd=7, load arrives under 3 cycles of ALU traffic
    issue_valid_i = 1'b1; issue_rd_i = 5'd7; #1;
    chk("ld7.issue_ready", 64'(issue_ready_o), 64'd1);
    step();
    issue_valid_i = 1'b0;
    chk("ld7.busy0", 64'(busy_a_o), 64'd1);
    alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'hA1;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 32'h11;
    step();
    lsu_valid_i = 1'b0;
    chk_wr("ld7.alu1", 1'b1, 5'd1, 32'hA1);
    chk("ld7.busy1", 64'(busy_a_o), 64'd1);
    alu_rd_i = 5'd2; alu_data_i = 32'hA2;
    step();
    chk_wr("ld7.alu2", 1'b1, 5'd2, 32'hA2);
    chk("ld7.busy2", 64'(busy_a_o), 64'd1);
    alu_rd_i = 5'd3; alu_data_i = 32'hA3;
    step();
    chk_wr("ld7.alu3", 1'b1, 5'd3, 32'hA3);
    alu_valid_i = 1'b0; #1;
    chk("ld7.busy_pop_cycle", 64'(busy_a_o), 64'd1);
    step();
    chk_wr("ld7.load", 1'b1, 5'd7, 32'h11);
    chk("ld7.busy_cleared", 64'(busy_a_o), 64'd0);
    step();
    chk_wr("ld7.idle", 1'b0, 5'd0, 32'd0);

    // Three loads under continuous ALU traffic: FIFO fills, then drains in order
    alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_data_i = 32'h44;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_data_i = 32'hA;
    step();
    lsu_rd_i = 5'd11; lsu_data_i = 32'hB;
    step();
    chk("fill.ready_after2", 64'(lsu_ready_o), 64'd0);
    lsu_rd_i = 5'd12; lsu_data_i = 32'hC;
    step();
    chk("fill.ready_held", 64'(lsu_ready_o), 64'd0);
    chk_wr("fill.alu", 1'b1, 5'd4, 32'h44);
    alu_valid_i = 1'b0;
    step();
    chk_wr("drain.first", 1'b1, 5'd10, 32'hA);
    chk("drain.ready", 64'(lsu_ready_o), 64'd1);
    step();
    lsu_valid_i = 1'b0;
    chk_wr("drain.second", 1'b1, 5'd11, 32'hB);
    step();
    chk_wr("drain.third", 1'b1, 5'd12, 32'hC);
    step();
    chk_wr("drain.idle", 1'b0, 5'd0, 32'd0);

    // Second outstanding load to rd=9 stalls until the first one retires
    issue_valid_i = 1'b1; issue_rd_i = 5'd9; #1;
    chk("rd9.first_ready", 64'(issue_ready_o), 64'd1);
    step();
    chk("rd9.second_ready", 64'(issue_ready_o), 64'd0);
    step();
    chk("rd9.stall", 64'(issue_ready_o), 64'd0);
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h99;
    step();
    lsu_valid_i = 1'b0;
    chk("rd9.stall_pushed", 64'(issue_ready_o), 64'd0);
    step();
    chk_wr("rd9.load", 1'b1, 5'd9, 32'h99);
    chk("rd9.ready_after_pop", 64'(issue_ready_o), 64'd1);
    step();
    issue_valid_i = 1'b0;
    raddr_a_i = 5'd9; #1;
    chk("rd9.busy_reissued", 64'(busy_a_o), 64'd1);

    // rd=0 handling: ALU, issue, and a popped FIFO entry
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hFFFFFFFF;
    step();
    alu_valid_i = 1'b0;
    chk("rd0.alu_we", 64'(we_a_o), 64'd0);
    issue_valid_i = 1'b1; issue_rd_i = 5'd0; #1;
    chk("rd0.issue_ready", 64'(issue_ready_o), 64'd1);
    step();
    issue_valid_i = 1'b0;
    raddr_b_i = 5'd0; #1;
    chk("rd0.busy", 64'(busy_b_o), 64'd0);
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd0; lsu_data_i = 32'h5;
    step();
    lsu_rd_i = 5'd3; lsu_data_i = 32'h6;
    step();
    lsu_valid_i = 1'b0;
    chk("rd0.fifo_we", 64'(we_a_o), 64'd0);
    step();
    chk_wr("rd0.next_entry", 1'b1, 5'd3, 32'h6);

    // Reset mid-operation with two buffered loads and pending bits set
    issue_valid_i = 1'b1; issue_rd_i = 5'd13;
    step();
    issue_valid_i = 1'b0;
    raddr_b_i = 5'd13; #1;
    chk("mid.busy13_set", 64'(busy_b_o), 64'd1);
    alu_valid_i = 1'b1; alu_rd_i = 5'd2; alu_data_i = 32'h22;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd20; lsu_data_i = 32'h20;
    step();
    lsu_rd_i = 5'd21; lsu_data_i = 32'h21;
    step();
    chk("mid.full", 64'(lsu_ready_o), 64'd0);
    rst = 1'b1; alu_valid_i = 1'b0;
    issue_valid_i = 1'b1; issue_rd_i = 5'd14;
    step();
    rst = 1'b0; lsu_valid_i = 1'b0; issue_valid_i = 1'b0;
    chk("mid.we", 64'(we_a_o), 64'd0);
    chk("mid.busy9", 64'(busy_a_o), 64'd0);
    chk("mid.busy13", 64'(busy_b_o), 64'd0);
    chk("mid.lsu_ready", 64'(lsu_ready_o), 64'd1);
    raddr_b_i = 5'd14; #1;
    chk("mid.busy14", 64'(busy_b_o), 64'd0);
    issue_rd_i = 5'd9; #1;
    chk("mid.issue_ready", 64'(issue_ready_o), 64'd1);
    step();
    chk("mid.no_write", 64'(we_a_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
